stream_run_ctrl: RTL
====================

STREAM_RUN_CTRL -- requirements
Module: stream_run_ctrl

Interface
REQ-001 The block SHALL have parameter C_NUM_CHANNELS, default 2, giving the number of input AXI-stream channels joined into the kernel.
REQ-002 The block SHALL have parameter C_CNT_WIDTH, default 32, giving the width of the length and beat counters.
REQ-003 aclk  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 areset  in  1  reset; it SHALL be synchronous and active-high.
REQ-005 ap_start  in  1  run request; it SHALL be sampled only in IDLE.
REQ-006 ap_len  in  C_CNT_WIDTH  number of vector beats in the run; it SHALL be latched when ap_start is accepted.
REQ-007 ap_busy  out  1  high while a run is in progress.
REQ-008 ap_done  out  1  one-cycle completion pulse.
REQ-009 s_tvalid  in  C_NUM_CHANNELS  upstream per-channel valid.
REQ-010 s_tready  out  C_NUM_CHANNELS  upstream per-channel ready.
REQ-011 k_ivalid  out  1  kernel (main) input valid.
REQ-012 k_iready  in  1  kernel input back-pressure.
REQ-013 k_ovalid  in  1  kernel output valid.
REQ-014 k_oready  out  1  ready to the kernel output.
REQ-015 m_tvalid  out  1  downstream valid.
REQ-016 m_tready  in  1  downstream ready.
REQ-017 in_beats  out  C_CNT_WIDTH  accepted input beats in the current or last run.
REQ-018 out_beats  out  C_CNT_WIDTH  delivered output beats in the current or last run.

Function
REQ-019 The block SHALL implement the FSM states IDLE, RUN, DRAIN and DONE, held in registers.
REQ-020 IDLE: on ap_start=1 with ap_len!=0 -> RUN, latching len and clearing both counters.
REQ-021 IDLE: on ap_start=1 with ap_len=0 -> DONE, clearing both counters.
REQ-022 ap_start SHALL be ignored in RUN, DRAIN and DONE; the latched len SHALL NOT change mid-run.
REQ-023 RUN input join: k_ivalid = &s_tvalid, and every bit of s_tready = k_iready & (&s_tvalid), so all channels transfer in the same cycle.
REQ-024 Input fire SHALL be k_ivalid & k_iready; in_beats SHALL increment by 1 on each fire.
REQ-025 RUN, input fire with in_beats==len-1: the FSM SHALL go to DRAIN.
REQ-026 RUN, input fire with in_beats==len-1 and a simultaneous output fire with out_beats==len-1: the FSM SHALL go to DONE.
REQ-027 In RUN and DRAIN, output SHALL pass through combinationally: m_tvalid=k_ovalid and k_oready=m_tready.
REQ-028 Output fire SHALL be k_ovalid & m_tready; out_beats SHALL increment by 1 on each fire.
REQ-029 DRAIN: s_tready SHALL be all 0 and k_ivalid SHALL be 0.
REQ-030 DRAIN, output fire with out_beats==len-1: the FSM SHALL go to DONE.
REQ-031 In IDLE and DONE: s_tready=0, k_ivalid=0, m_tvalid=0 and k_oready=0; a stray k_ovalid SHALL NOT be counted.
REQ-032 DONE SHALL last exactly one cycle with ap_done=1, then go to IDLE.
REQ-033 ap_busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-034 Zero-cycle latency: handshakes pass through in the same cycle; ap_done SHALL assert the cycle after the final output fire.
REQ-035 Counters SHALL never exceed len, and they SHALL hold their values in IDLE for readback until the next accepted start.
REQ-036 The counter compare SHALL be unsigned at full width; len=2^C_CNT_WIDTH-1 SHALL be supported without wrap.

Reset
REQ-037 With areset=1 at a clock edge, the next state SHALL be IDLE, in_beats=0, out_beats=0, latched len=0 and ap_done=0, regardless of any in-flight run.
REQ-038 During and after reset, all outputs SHALL be 0 (ap_busy, ap_done, s_tready, k_ivalid, k_oready, m_tvalid) until a new ap_start.

Verification
REQ-039 len=4, all inputs and readies always 1, kernel latency 3 -> 4 input fires in cycles 1-4, DRAIN from cycle 5, 4 output fires, ap_done one cycle after the 4th output, in_beats=out_beats=4.
REQ-040 len=3, s_tvalid=2'b01 for 5 cycles then 2'b11 -> no s_tready and no k_ivalid during the 5 cycles, then normal completion with in_beats=3.
REQ-041 len=0 start -> ap_done the next cycle, ap_busy never 1, counters 0.
REQ-042 len=8, m_tready toggling 1/0, k_iready low every 3rd cycle -> exactly 8 beats each side, no fire in IDLE/DONE, single ap_done pulse.
REQ-043 areset=1 in DRAIN with out_beats=2 of len=5 -> next cycle IDLE, all outputs 0, counters 0; a following start with len=2 completes normally.
REQ-044 ap_start held high throughout a len=2 run -> second run starts only from IDLE after DONE, with len re-latched.

Source files
------------

// File: rtl/stream_run_ctrl.sv
// stream_run_ctrl: run controller that joins C_NUM_CHANNELS AXI-stream inputs
// into a kernel, passes kernel output downstream, and counts beats per run.
// Handshakes pass through combinationally; only the run state and counters
// are registered.
module stream_run_ctrl #(
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_CNT_WIDTH    = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      ap_start,
    input  logic [C_CNT_WIDTH-1:0]    ap_len,
    output logic                      ap_busy,
    output logic                      ap_done,
    input  logic [C_NUM_CHANNELS-1:0] s_tvalid,
    output logic [C_NUM_CHANNELS-1:0] s_tready,
    output logic                      k_ivalid,
    input  logic                      k_iready,
    input  logic                      k_ovalid,
    output logic                      k_oready,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [C_CNT_WIDTH-1:0]    in_beats,
    output logic [C_CNT_WIDTH-1:0]    out_beats
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

    state_t                   state;
    state_t                   state_nxt;
    logic [C_CNT_WIDTH-1:0]   len_q;
    logic [C_CNT_WIDTH-1:0]   len_nxt;
    logic [C_CNT_WIDTH-1:0]   in_cnt;
    logic [C_CNT_WIDTH-1:0]   in_cnt_nxt;
    logic [C_CNT_WIDTH-1:0]   out_cnt;
    logic [C_CNT_WIDTH-1:0]   out_cnt_nxt;
    logic [C_CNT_WIDTH-1:0]   len_last;
    logic                     all_valid;
    logic                     in_last;
    logic                     out_last;
    logic                     out_full;
    logic                     in_fire;
    logic                     out_fire;

    // len is never zero while in RUN/DRAIN, so len-1 cannot wrap there;
    // compares are unsigned at full width so the maximum length works.
    assign all_valid = &s_tvalid;
    assign len_last  = len_q - CNT_ONE;
    assign in_last   = (in_cnt == len_last);
    assign out_last  = (out_cnt == len_last);
    assign out_full  = (out_cnt == len_q);

    assign in_beats  = in_cnt;
    assign out_beats = out_cnt;

    // Next-state, counter updates and all handshake outputs for the current state
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        ap_busy     = 1'b0;
        ap_done     = 1'b0;
        s_tready    = '0;
        k_ivalid    = 1'b0;
        k_oready    = 1'b0;
        m_tvalid    = 1'b0;
        in_fire     = 1'b0;
        out_fire    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ap_start) begin
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                    len_nxt     = ap_len;
                    if (ap_len != '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                ap_busy  = 1'b1;
                k_ivalid = all_valid;
                s_tready = {C_NUM_CHANNELS{all_valid & k_iready}};
                m_tvalid = k_ovalid;
                k_oready = m_tready;
                in_fire  = all_valid & k_iready;
                out_fire = k_ovalid & m_tready & ~out_full;
                if (in_fire) begin
                    in_cnt_nxt = in_cnt + CNT_ONE;
                end
                if (out_fire) begin
                    out_cnt_nxt = out_cnt + CNT_ONE;
                end
                // Last input beat: finish outright if the output side completes
                // in the same cycle (or somehow already has), otherwise drain.
                if (in_fire && in_last) begin
                    if ((out_fire && out_last) || out_full) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                ap_busy  = 1'b1;
                m_tvalid = k_ovalid;
                k_oready = m_tready;
                out_fire = k_ovalid & m_tready & ~out_full;
                if (out_fire) begin
                    out_cnt_nxt = out_cnt + CNT_ONE;
                end
                if (out_fire && out_last) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                ap_done   = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // While reset is asserted every handshake output is forced quiet,
        // even before the state register has been cleared.
        if (areset) begin
            ap_busy  = 1'b0;
            ap_done  = 1'b0;
            s_tready = '0;
            k_ivalid = 1'b0;
            k_oready = 1'b0;
            m_tvalid = 1'b0;
        end
    end

    // State, latched length and beat counters; synchronous reset clears all
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

endmodule
